// File: rtl/wb_watch_pkg.sv
// Shared constants for the watch timekeeping core: register offsets,
// control/status bit positions and the per-channel register stride.
package wb_watch_pkg;

    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_STATUS = 'h04;

    // Channel i occupies CH_BASE + CH_STRIDE*i; the stride is one address nibble
    localparam int CH_BASE   = 'h10;
    localparam int CH_STRIDE = 'h10;

    localparam logic [3:0] CH_VALUE = 4'h0;
    localparam logic [3:0] CH_LIMIT = 4'h4;
    localparam logic [3:0] CH_ALARM = 4'h8;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_ALARM_EN = 2;
    localparam int CTRL_SOFT_CLR = 3;

    localparam int STATUS_ALARM = 0;

    typedef struct packed {
        logic alarm_en;
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/wb_watch_if.sv
// Wishbone slave bus bundle for the watch core (32-bit data, byte address).
interface wb_watch_if;
    import wb_watch_pkg::*;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);

endinterface

// File: rtl/wb_watch_chan.sv
// One counter channel: value/limit/alarm registers, wrap-to-zero on advance
// at or above the limit, and an alarm equality flag.
module wb_watch_chan
    import wb_watch_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             clear,
    input  logic             wr_value,
    input  logic             wr_limit,
    input  logic             wr_alarm,
    input  logic [31:0]      wdat,
    input  logic [3:0]       sel,
    output logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] alarm,
    output logic             at_limit,
    output logic             match
);

    logic [CNT_W-1:0] value_m;
    logic [CNT_W-1:0] limit_m;
    logic [CNT_W-1:0] alarm_m;
    logic             unused_in;

    assign unused_in = ^{wdat, sel};
    assign at_limit  = (value >= limit);
    assign match     = (value == alarm);

    // Byte-lane merge of the write word into each register's current contents
    always_comb begin
        value_m = value;
        limit_m = limit;
        alarm_m = alarm;
        for (int b = 0; b < CNT_W; b++) begin
            if (sel[b >> 3]) begin
                value_m[b] = wdat[b];
                limit_m[b] = wdat[b];
                alarm_m[b] = wdat[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            limit <= '1;
            alarm <= '0;
        end else begin
            if (clear)
                value <= '0;
            else if (wr_value)
                value <= value_m;
            else if (adv)
                value <= at_limit ? '0 : value + CNT_W'(1);
            if (wr_limit)
                limit <= limit_m;
            if (wr_alarm)
                alarm <= alarm_m;
        end
    end

endmodule

// File: rtl/wb_watch_ctrl.sv
// Wishbone-slave timekeeping core: bus decode, control/status, carry ripple
// across the cascaded channels, alarm edge detect and interrupt.
module wb_watch_ctrl
    import wb_watch_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 8,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    wb_watch_if.slave               bus,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic                    carry,
    output logic                    irq
);

    logic              ack_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] off_q;
    logic [31:0]       wdat_q;
    logic              req;
    logic              commit;
    logic              wr_ctrl;
    logic              soft_clr;
    logic              status_clr;
    ctrl_t             ctrl;
    logic              status;
    logic              match_prev;
    logic              match_all;
    logic [31:0]       rdata;

    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] wr_value;
    logic [NUM_CH-1:0] wr_limit;
    logic [NUM_CH-1:0] wr_alarm;
    logic [NUM_CH-1:0] at_limit;
    logic [NUM_CH-1:0] match_ch;
    logic [NUM_CH-1:0] adv;
    logic [CNT_W-1:0]  value_a [NUM_CH];
    logic [CNT_W-1:0]  limit_a [NUM_CH];
    logic [CNT_W-1:0]  alarm_a [NUM_CH];

    assign req        = bus.cyc & bus.stb & ~ack_q &
                        (bus.adr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign commit     = ack_q & we_q;
    assign wr_ctrl    = commit & (off_q == ADDR_W'(OFF_CTRL));
    assign soft_clr   = wr_ctrl & sel_q[0] & wdat_q[CTRL_SOFT_CLR];
    assign status_clr = commit & (off_q == ADDR_W'(OFF_STATUS)) &
                        sel_q[0] & wdat_q[STATUS_ALARM];
    assign match_all  = &match_ch;
    assign irq        = status & ctrl.irq_en;

    // Request is captured when accepted so a dropped cyc still completes the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            off_q  <= '0;
            wdat_q <= '0;
        end else begin
            ack_q <= req;
            if (req) begin
                we_q   <= bus.we;
                sel_q  <= bus.sel;
                off_q  <= bus.adr[ADDR_W-1:0];
                wdat_q <= bus.dat_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl       <= '0;
            status     <= 1'b0;
            match_prev <= 1'b0;
        end else begin
            match_prev <= match_all;
            if (wr_ctrl && sel_q[0]) begin
                ctrl.en       <= wdat_q[CTRL_EN];
                ctrl.irq_en   <= wdat_q[CTRL_IRQ_EN];
                ctrl.alarm_en <= wdat_q[CTRL_ALARM_EN];
            end
            if (soft_clr)
                status <= 1'b0;
            else if (ctrl.alarm_en && match_all && !match_prev)
                status <= 1'b1;
            else if (status_clr)
                status <= 1'b0;
        end
    end

    // A VALUE write on a channel swallows that channel's advance and its carry
    always_comb begin
        logic c;
        c = ctrl.en & tick & ~soft_clr;
        for (int i = 0; i < NUM_CH; i++) begin
            adv[i] = c;
            c      = c & at_limit[i] & ~wr_value[i];
        end
        carry = c;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_hit[i]   = (off_q[ADDR_W-1:4] == (ADDR_W-4)'(CH_BASE / CH_STRIDE + i));
        assign wr_value[i] = commit & ch_hit[i] & (off_q[3:0] == CH_VALUE);
        assign wr_limit[i] = commit & ch_hit[i] & (off_q[3:0] == CH_LIMIT);
        assign wr_alarm[i] = commit & ch_hit[i] & (off_q[3:0] == CH_ALARM);

        wb_watch_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv[i]),
            .clear    (soft_clr),
            .wr_value (wr_value[i]),
            .wr_limit (wr_limit[i]),
            .wr_alarm (wr_alarm[i]),
            .wdat     (wdat_q),
            .sel      (sel_q),
            .value    (value_a[i]),
            .limit    (limit_a[i]),
            .alarm    (alarm_a[i]),
            .at_limit (at_limit[i]),
            .match    (match_ch[i])
        );

        assign cnt[i*CNT_W +: CNT_W] = value_a[i];
    end

    always_comb begin
        rdata = '0;
        if (off_q == ADDR_W'(OFF_CTRL))
            rdata[2:0] = {ctrl.alarm_en, ctrl.irq_en, ctrl.en};
        else if (off_q == ADDR_W'(OFF_STATUS))
            rdata[STATUS_ALARM] = status;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                case (off_q[3:0])
                    CH_VALUE: rdata = 32'(value_a[i]);
                    CH_LIMIT: rdata = 32'(limit_a[i]);
                    CH_ALARM: rdata = 32'(alarm_a[i]);
                    default:  ;
                endcase
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.dat_r = ack_q ? rdata : '0;

endmodule
